pc_fetch_unit: RTL and testbench

Program counter and instruction-fetch sequencer for the RISC datapath. Holds the architectural PC, issues one instruction-memory read at a time, and hands the fetched word plus its PC to decode through a valid/ready handshake. After each fetch it advances the PC by 4, which makes it the sequential consumer of the PC+4 increment. A taken branch or jump from execute redirects it.

---
 rtl/pc_fetch_unit_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input, halt,
// and the decode-side valid/ready handshake.
// The master modport is the fetch unit. The slave modport is the environment,
// meaning memory, execute and decode.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign,
    input  imem_ack, imem_rdata, br_valid, br_target, halt, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign,
    output imem_ack, imem_rdata, br_valid, br_target, halt, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC and single-outstanding instruction fetch
// sequencer. It presents {pc, instr} to decode through valid/ready.
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned redirects
// into a sticky ERR state. When it is undefined, redirect targets are
// word-aligned by force and misalign reads 0.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_unit_if.master bus
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic [31:0] pc_inc;
  logic [31:0] br_pc;

  // PC+4 wraps modulo 2^32 because the carry out is dropped.
  assign pc_inc = pc_q + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic br_misaligned;

  // A misaligned target never reaches pc, so it is loaded unmodified.
  assign br_pc         = bus.br_target;
  assign br_misaligned = (bus.br_target[1:0] != 2'b00);
  assign bus.misalign  = misalign_q;
`else
  // The low bits are cleared so that pc always stays word-aligned.
  assign br_pc         = bus.br_target & 32'hFFFF_FFFC;
  assign bus.misalign  = 1'b0;
`endif

  // Sequencer state, PC and all registered outputs.
  // Redirect takes priority over every state transition. The imem_addr
  // register follows pc, so a redirect moves the address in the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end
`ifdef PC_ALIGN_CHECK_EN
    else if (state_q == ERR) begin
      imem_req_q <= 1'b0;
    end else if (bus.br_valid && br_misaligned) begin
      misalign_q <= 1'b1;
      if_valid_q <= 1'b0;
      imem_req_q <= 1'b0;
      state_q    <= ERR;
    end
`endif
    else if (bus.br_valid) begin
      pc_q        <= br_pc;
      imem_addr_q <= br_pc;
      if_valid_q  <= 1'b0;
      if (bus.halt) begin
        state_q    <= IDLE;
        imem_req_q <= 1'b0;
      end else begin
        state_q    <= REQ;
        imem_req_q <= 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.halt) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if_instr_q  <= bus.imem_rdata;
            if_pc_q     <= pc_q;
            if_valid_q  <= 1'b1;
            pc_q        <= pc_inc;
            imem_addr_q <= pc_inc;
            imem_req_q  <= 1'b0;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.if_ready) begin
            if_valid_q <= 1'b0;
            if (bus.halt) begin
              state_q <= IDLE;
            end else begin
              state_q    <= REQ;
              imem_req_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. The memory returns addr ^ 32'hDEAD_0000.
// u0 resets to 0 and u1 resets to 32'hFFFF_FFFC so the PC wrap can be seen.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  pc_fetch_unit_if b0 ();
  pc_fetch_unit_if b1 ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst(rst), .bus(b0.master));
  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (.clk(clk), .rst(rst), .bus(b1.master));

  always #5 clk = ~clk;

  assign b0.imem_rdata = b0.imem_addr ^ 32'hDEAD_0000;
  assign b1.imem_rdata = b1.imem_addr ^ 32'hDEAD_0000;
  assign b1.imem_ack   = 1'b1;
  assign b1.if_ready   = 1'b1;
  assign b1.halt       = 1'b0;
  assign b1.br_valid   = 1'b0;
  assign b1.br_target  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, b0.imem_req}, 32'd1);
    chk({tag, ".addr"}, b0.imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, b0.if_valid}, 32'd0);
  endtask

  task automatic chk_hold(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'd0, b0.if_valid}, 32'd1);
    chk({tag, ".pc"}, b0.if_pc, pc);
    chk({tag, ".instr"}, b0.if_instr, instr);
    chk({tag, ".req"}, {31'd0, b0.imem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.imem_ack  = 1'b1;
    b0.if_ready  = 1'b1;
    b0.halt      = 1'b0;
    b0.br_valid  = 1'b0;
    b0.br_target = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst.req", {31'd0, b0.imem_req}, 32'd0);
    chk("rst.addr", b0.imem_addr, 32'h0);
    chk("rst.valid", {31'd0, b0.if_valid}, 32'd0);
    chk("rst.pc", b0.if_pc, 32'h0);
    chk("rst.instr", b0.if_instr, 32'h0);
    chk("rst.mis", {31'd0, b0.misalign}, 32'd0);
    chk("rst.addr_u1", b1.imem_addr, 32'hFFFF_FFFC);

    // Release reset. Cycle 1 is IDLE, with no request.
    rst = 1'b0;
    tick();
    chk("c2", {31'd0, b0.imem_req}, 32'd1);
    chk("c2.addr", b0.imem_addr, 32'h0);
    chk("c2.u1addr", b1.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk_hold("seq0", 32'h0, 32'hDEAD_0000);
    chk("wrap.pc", b1.if_pc, 32'hFFFF_FFFC);
    tick();
    chk_req("seq1r", 32'h4);
    chk("wrap.addr", b1.imem_addr, 32'h0000_0000);
    tick();
    chk_hold("seq1", 32'h4, 32'hDEAD_0004);
    chk("wrap.pc2", b1.if_pc, 32'h0000_0000);
    tick();
    chk_req("seq2r", 32'h8);
    tick();
    chk_hold("seq2", 32'h8, 32'hDEAD_0008);
    tick();
    chk_req("seq3r", 32'hC);
    tick();
    chk_hold("seq3", 32'hC, 32'hDEAD_000C);

    // Decode backpressure for 5 cycles.
    b0.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_hold("bp", 32'hC, 32'hDEAD_000C);
    end
    b0.if_ready = 1'b1;
    tick();
    chk_req("bprel", 32'h10);

    // A redirect arrives in the same cycle as the ack for 0x10.
    b0.br_valid  = 1'b1;
    b0.br_target = 32'h100;
    tick();
    b0.br_valid = 1'b0;
    chk_req("redir", 32'h100);
    tick();
    chk_hold("redir0", 32'h100, 32'hDEAD_0100);
    tick();
    chk_req("redir1r", 32'h104);
    tick();
    chk_hold("redir1", 32'h104, 32'hDEAD_0104);
    tick();
    chk_req("haltr", 32'h108);

    // Halt asserted mid-REQ while the memory is waiting.
    b0.imem_ack = 1'b0;
    b0.halt     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_req("wait", 32'h108);
    end
    b0.imem_ack = 1'b1;
    tick();
    chk_hold("haltd", 32'h108, 32'hDEAD_0108);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("park.req", {31'd0, b0.imem_req}, 32'd0);
      chk("park.valid", {31'd0, b0.if_valid}, 32'd0);
    end
    b0.halt = 1'b0;
    tick();
    chk_req("resume", 32'h10C);

    // Misaligned redirect.
    b0.br_valid  = 1'b1;
    b0.br_target = 32'h102;
    tick();
    b0.br_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("mis.flag", {31'd0, b0.misalign}, 32'd1);
    chk("mis.req", {31'd0, b0.imem_req}, 32'd0);
    b0.br_valid  = 1'b1;
    b0.br_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err.req", {31'd0, b0.imem_req}, 32'd0);
      chk("err.flag", {31'd0, b0.misalign}, 32'd1);
    end
    b0.br_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err.rst", {31'd0, b0.misalign}, 32'd0);
`else
    chk_req("mis", 32'h100);
    chk("mis.flag", {31'd0, b0.misalign}, 32'd0);
    tick();
    chk_hold("mis0", 32'h100, 32'hDEAD_0100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
